// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (1280x1024@60, 108 MHz) and colour-word field positions.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;

    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // color_in is packed {R, G, B}, four bits each
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with asynchronous reset to a per-bit value; DEPTH=0 is a wire.
module sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH < 0 || DEPTH > 4) begin : g_depth_chk
        $error("sync_delay: DEPTH %0d outside 0..4", DEPTH);
    end

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing master: issues pixel coordinates, takes colour back LATENCY cycles
// later, and drives RGB/HS/VS/DE with sync delayed to match the colour path.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b1,
    parameter int   LATENCY  = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        active,
    output logic        frame_start,
    input  logic [11:0] color_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL %0d exceeds 4096", H_TOTAL);
    end
    if (V_TOTAL > 2048) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL %0d exceeds 2048", V_TOTAL);
    end
    if (LATENCY < 0 || LATENCY > 4) begin : g_latency_chk
        $error("vga_timing_gen: LATENCY %0d outside 0..4", LATENCY);
    end

    // Compare bounds carry one spare bit so an end value equal to the total cannot alias to 0
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [11:0] h_next;
    logic [10:0] v_cnt;
    logic [10:0] v_next;

    always_comb begin
        h_next = h_cnt + 12'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end
    end

    // active/frame_start are decoded from the next count so they stay aligned with x/y
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            active      <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            active      <= ({1'b0, h_next} < H_ACT) && ({1'b0, v_next} < V_ACT);
            frame_start <= (h_next == 12'd0) && (v_next == 11'd0);
        end
    end

    assign x = h_cnt;
    assign y = v_cnt;

    logic hs_raw;
    logic vs_raw;
    logic de_raw;

    assign hs_raw = ({1'b0, h_cnt} >= HS_START) && ({1'b0, h_cnt} < HS_END);
    assign vs_raw = ({1'b0, v_cnt} >= VS_START) && ({1'b0, v_cnt} < VS_END);
    assign de_raw = active;

    logic hs_d;
    logic vs_d;
    logic de_d;

    sync_delay #(
        .DEPTH   (LATENCY),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_sync_delay (
        .clock (clock),
        .reset (reset),
        .d     ({hs_raw, vs_raw, de_raw}),
        .q     ({hs_d, vs_d, de_d})
    );

    // Final pin register: colour is sampled every cycle and blacked out outside the active area
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_de <= 1'b0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else begin
            vga_r  <= de_d ? color_in[R_MSB:R_LSB] : 4'h0;
            vga_g  <= de_d ? color_in[G_MSB:G_LSB] : 4'h0;
            vga_b  <= de_d ? color_in[B_MSB:B_LSB] : 4'h0;
            vga_de <= de_d;
            vga_hs <= hs_d ~^ SYNC_POL;
            vga_vs <= vs_d ~^ SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size line timing from a vector table, plus reduced
// rasters at LATENCY 0/1/3 checked every cycle against a closed-form raster model.
module tb_vga_timing_gen;

    localparam int S_HA  = 16;
    localparam int S_HFP = 4;
    localparam int S_HSW = 6;
    localparam int S_HBP = 6;
    localparam int S_VA  = 12;
    localparam int S_VFP = 2;
    localparam int S_VSW = 3;
    localparam int S_VBP = 3;

    typedef struct packed {
        logic [11:0] x;
        logic [10:0] y;
        logic        active;
        logic        fs;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } out_t;

    typedef struct {
        int   ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
        logic pol;
    } timing_t;

    typedef struct {
        int          n;
        int          x;
        int          y;
        logic        active;
        logic        fs;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] big_color = 12'hF0F;
    logic [11:0] small_color = 12'h000;

    int error_count = 0;
    int check_count = 0;

    timing_t t_big, t_s0, t_s1, t_s3;
    vec_t    vecs [15];

    always #5 clock = ~clock;

    logic [11:0] big_x, s0_x, s1_x, s3_x;
    logic [10:0] big_y, s0_y, s1_y, s3_y;
    logic        big_active, s0_active, s1_active, s3_active;
    logic        big_fs, s0_fs, s1_fs, s3_fs;
    logic [3:0]  big_r, s0_r, s1_r, s3_r;
    logic [3:0]  big_g, s0_g, s1_g, s3_g;
    logic [3:0]  big_b, s0_b, s1_b, s3_b;
    logic        big_hs, s0_hs, s1_hs, s3_hs;
    logic        big_vs, s0_vs, s1_vs, s3_vs;
    logic        big_de, s0_de, s1_de, s3_de;

    vga_timing_gen #(.LATENCY(1)) u_big (
        .clock(clock), .reset(reset), .x(big_x), .y(big_y), .active(big_active),
        .frame_start(big_fs), .color_in(big_color), .vga_r(big_r), .vga_g(big_g),
        .vga_b(big_b), .vga_hs(big_hs), .vga_vs(big_vs), .vga_de(big_de)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .SYNC_POL(1'b0), .LATENCY(0)
    ) u_s0 (
        .clock(clock), .reset(reset), .x(s0_x), .y(s0_y), .active(s0_active),
        .frame_start(s0_fs), .color_in(small_color), .vga_r(s0_r), .vga_g(s0_g),
        .vga_b(s0_b), .vga_hs(s0_hs), .vga_vs(s0_vs), .vga_de(s0_de)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .SYNC_POL(1'b1), .LATENCY(1)
    ) u_s1 (
        .clock(clock), .reset(reset), .x(s1_x), .y(s1_y), .active(s1_active),
        .frame_start(s1_fs), .color_in(small_color), .vga_r(s1_r), .vga_g(s1_g),
        .vga_b(s1_b), .vga_hs(s1_hs), .vga_vs(s1_vs), .vga_de(s1_de)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .SYNC_POL(1'b1), .LATENCY(3)
    ) u_s3 (
        .clock(clock), .reset(reset), .x(s3_x), .y(s3_y), .active(s3_active),
        .frame_start(s3_fs), .color_in(small_color), .vga_r(s3_r), .vga_g(s3_g),
        .vga_b(s3_b), .vga_hs(s3_hs), .vga_vs(s3_vs), .vga_de(s3_de)
    );

    out_t act_big, act_s0, act_s1, act_s3;
    assign act_big = {big_x, big_y, big_active, big_fs, big_r, big_g, big_b, big_hs, big_vs, big_de};
    assign act_s0  = {s0_x, s0_y, s0_active, s0_fs, s0_r, s0_g, s0_b, s0_hs, s0_vs, s0_de};
    assign act_s1  = {s1_x, s1_y, s1_active, s1_fs, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_de};
    assign act_s3  = {s3_x, s3_y, s3_active, s3_fs, s3_r, s3_g, s3_b, s3_hs, s3_vs, s3_de};

    // Expected outputs n cycles after reset release; col is the colour on the bus before that edge
    function automatic out_t model(input int n, input timing_t t, input logic [11:0] col);
        out_t o;
        int   ht, vt, cnt, h, v, p;
        ht = t.ha + t.hfp + t.hsw + t.hbp;
        vt = t.va + t.vfp + t.vsw + t.vbp;
        cnt = n % (ht * vt);
        h = cnt % ht;
        v = cnt / ht;
        o.x = 12'(h);
        o.y = 11'(v);
        o.active = (h < t.ha) && (v < t.va);
        o.fs = (cnt == 0);
        p = n - t.lat - 1;
        if (p < 0) begin
            o.rgb = 12'h000;
            o.de  = 1'b0;
            o.hs  = ~t.pol;
            o.vs  = ~t.pol;
        end else begin
            cnt = p % (ht * vt);
            h = cnt % ht;
            v = cnt / ht;
            o.de  = (h < t.ha) && (v < t.va);
            o.hs  = (h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hsw) ? t.pol : ~t.pol;
            o.vs  = (v >= t.va + t.vfp && v < t.va + t.vfp + t.vsw) ? t.pol : ~t.pol;
            o.rgb = o.de ? col : 12'h000;
        end
        return o;
    endfunction

    task automatic check_output(input string name, input int n, input out_t act, input out_t exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s n=%0d got x=%0d y=%0d act=%b fs=%b rgb=%h hs=%b vs=%b de=%b, expected x=%0d y=%0d act=%b fs=%b rgb=%h hs=%b vs=%b de=%b",
                     name, n, act.x, act.y, act.active, act.fs, act.rgb, act.hs, act.vs, act.de,
                     exp.x, exp.y, exp.active, exp.fs, exp.rgb, exp.hs, exp.vs, exp.de);
        end
    endtask

    task automatic check_value(input string name, input int act, input int exp);
        check_count++;
        if (act != exp) begin
            error_count++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int n);
        small_color = 12'((n * 37) ^ 12'h5A3);
        big_color   = (n >= 1600) ? 12'h681 : 12'hF0F;
    endtask

    function automatic out_t vec_to_out(input vec_t v);
        out_t o;
        o.x = 12'(v.x);
        o.y = 11'(v.y);
        o.active = v.active;
        o.fs = v.fs;
        o.rgb = v.rgb;
        o.hs = v.hs;
        o.vs = v.vs;
        o.de = v.de;
        return o;
    endfunction

    initial begin
        int   de_rise1, de_rise2, de_len, hs_start, hs_len, blank_bad;
        int   vs_start, vs_len, fs_count, first_de_s0, first_de_s3;
        bit   de_done, hs_done, vs_done;
        logic prev_de, prev_hs, prev_vs;

        t_big = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1, 1'b1};
        t_s0  = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 0, 1'b0};
        t_s1  = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 1, 1'b1};
        t_s3  = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 3, 1'b1};

        // n, x, y, active, fs, de, hs, vs, rgb for the full-size LATENCY=1 instance
        vecs[0]  = '{0,    0,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{1,    1,    0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{2,    2,    0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hF0F};
        vecs[3]  = '{1279, 1279, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hF0F};
        vecs[4]  = '{1280, 1280, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hF0F};
        vecs[5]  = '{1281, 1281, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hF0F};
        vecs[6]  = '{1282, 1282, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{1329, 1329, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[8]  = '{1330, 1330, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[9]  = '{1441, 1441, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[10] = '{1442, 1442, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[11] = '{1687, 1687, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[12] = '{1688, 0,    1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[13] = '{1689, 1,    1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[14] = '{1690, 2,    1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h681};

        de_rise1 = -1; de_rise2 = -1; de_len = 0; de_done = 0;
        hs_start = -1; hs_len = 0; hs_done = 0; blank_bad = 0;
        vs_start = -1; vs_len = 0; vs_done = 0; fs_count = 0;
        first_de_s0 = -1; first_de_s3 = -1;
        prev_de = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0;

        // Power-on reset held for five cycles
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_hold_big", 0, act_big, model(0, t_big, big_color));
        check_output("reset_hold_s0", 0, act_s0, model(0, t_s0, small_color));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < 3434; n++) begin
            #1;
            for (int i = 0; i < 15; i++) begin
                if (vecs[i].n == n) check_output("line_vec", n, act_big, vec_to_out(vecs[i]));
            end
            check_output("s0_scan", n, act_s0, model(n, t_s0, small_color));
            check_output("s1_scan", n, act_s1, model(n, t_s1, small_color));
            check_output("s3_scan", n, act_s3, model(n, t_s3, small_color));

            if (act_big.de && !prev_de) begin
                if (de_rise1 < 0) de_rise1 = n;
                else if (de_rise2 < 0) de_rise2 = n;
            end
            if (de_rise1 >= 0 && !de_done) begin
                if (act_big.de) de_len++;
                else de_done = 1;
            end
            if (act_big.hs && !prev_hs && hs_start < 0) hs_start = n;
            if (hs_start >= 0 && !hs_done) begin
                if (act_big.hs) hs_len++;
                else hs_done = 1;
            end
            if (!act_big.de && act_big.rgb != 12'h000) blank_bad++;
            if (act_s1.vs && !prev_vs && vs_start < 0) vs_start = n;
            if (vs_start >= 0 && !vs_done) begin
                if (act_s1.vs) vs_len++;
                else vs_done = 1;
            end
            if (act_s1.fs) fs_count++;
            if (act_s0.de && first_de_s0 < 0) first_de_s0 = n;
            if (act_s3.de && first_de_s3 < 0) first_de_s3 = n;
            prev_de = act_big.de;
            prev_hs = act_big.hs;
            prev_vs = act_s1.vs;

            apply_stimulus(n);
            @(negedge clock);
        end

        check_value("de_first_rise", de_rise1, 2);
        check_value("de_run_length", de_len, 1280);
        check_value("line_period", de_rise2 - de_rise1, 1688);
        check_value("hs_first_rise", hs_start, 1330);
        check_value("hs_run_length", hs_len, 112);
        check_value("blank_rgb_nonzero", blank_bad, 0);
        check_value("s1_vs_first_rise", vs_start, 450);
        check_value("s1_vs_run_length", vs_len, 96);
        check_value("s1_frame_pulses", fs_count, 6);
        check_value("s0_first_de", first_de_s0, 1);
        check_value("s3_first_de", first_de_s3, 4);

        // Mid-frame asynchronous reset while s1 sits at (10,7)
        #1;
        check_value("s1_x_before_reset", int'(act_s1.x), 10);
        check_value("s1_y_before_reset", int'(act_s1.y), 7);
        reset = 1'b1;
        #1;
        check_output("reset_async_big", 0, act_big, model(0, t_big, big_color));
        check_output("reset_async_s0", 0, act_s0, model(0, t_s0, small_color));
        check_output("reset_async_s1", 0, act_s1, model(0, t_s1, small_color));
        check_output("reset_async_s3", 0, act_s3, model(0, t_s3, small_color));
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < 700; n++) begin
            #1;
            check_output("big_restart", n, act_big, model(n, t_big, big_color));
            check_output("s0_restart", n, act_s0, model(n, t_s0, small_color));
            check_output("s1_restart", n, act_s1, model(n, t_s1, small_color));
            check_output("s3_restart", n, act_s3, model(n, t_s3, small_color));
            apply_stimulus(n);
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
